// File: rtl/cvxif_result_collector.sv
// Collects CV-X-IF coprocessor results into a small FIFO for register-file writeback and tracks outstanding ids.
// Latency: a result accepted at edge N is visible on wb_* right after edge N; error pulses are registered (1 cycle).
// Backpressure: result_ready_o drops while the FIFO is full (no same-cycle bypass); wb side is plain valid/ready.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   issue_valid_i, issue_id_i        instruction offloaded with this id (sets scoreboard bit)
//   result_valid_i/result_ready_o    result handshake; result_{data,hartid,id,rd,we}_i payload
//   wb_valid_o/wb_ready_i            writeback handshake; wb_{data,hartid,id,rd,we}_o show the FIFO head
//   spurious_o                       pulse: accepted result had no outstanding issue
//   dup_issue_o                      pulse: issue named an id that was already outstanding
//   busy_o                           any id outstanding or FIFO not empty
module cvxif_result_collector #(
  parameter int Depth       = 4,
  parameter int IdWidth     = 4,
  parameter int HartIdWidth = 1,
  parameter int XLEN        = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   issue_valid_i,
  input  logic [IdWidth-1:0]     issue_id_i,
  input  logic                   result_valid_i,
  output logic                   result_ready_o,
  input  logic [XLEN-1:0]        result_data_i,
  input  logic [HartIdWidth-1:0] result_hartid_i,
  input  logic [IdWidth-1:0]     result_id_i,
  input  logic [4:0]             result_rd_i,
  input  logic                   result_we_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [XLEN-1:0]        wb_data_o,
  output logic [HartIdWidth-1:0] wb_hartid_o,
  output logic [IdWidth-1:0]     wb_id_o,
  output logic [4:0]             wb_rd_o,
  output logic                   wb_we_o,
  output logic                   spurious_o,
  output logic                   dup_issue_o,
  output logic                   busy_o
);

  localparam int AW    = $clog2(Depth);
  localparam int NumId = 2 ** IdWidth;

  typedef struct packed {
    logic [XLEN-1:0]        data;
    logic [HartIdWidth-1:0] hartid;
    logic [IdWidth-1:0]     id;
    logic [4:0]             rd;
    logic                   we;
  } entry_t;

  entry_t           r_mem [Depth];
  logic [AW-1:0]    r_rptr;
  logic [AW-1:0]    r_wptr;
  logic [AW:0]      r_count;
  logic [NumId-1:0] r_sb;
  logic             r_spurious;
  logic             r_dup;

  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_hit;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rptr_nxt;
  logic [AW-1:0]    w_wptr_nxt;
  logic [NumId-1:0] w_sb_nxt;
  entry_t           w_entry;
  entry_t           w_head;

  assign w_full   = (r_count == (AW+1)'(Depth));
  assign w_empty  = (r_count == '0);

  // Ready is looked at only on the registered count, so a pop cannot make room in the same cycle.
  assign result_ready_o = !w_full && !rst_i;
  assign w_accept = result_valid_i && result_ready_o;
  assign w_hit    = r_sb[result_id_i];
  assign w_push   = w_accept && w_hit;
  assign w_pop    = !w_empty && wb_ready_i;

  assign w_rptr_nxt = (r_rptr == AW'(Depth - 1)) ? '0 : r_rptr + 1'b1;
  assign w_wptr_nxt = (r_wptr == AW'(Depth - 1)) ? '0 : r_wptr + 1'b1;

  // rd = x0 is never written back, but the entry still travels to signal completion.
  always_comb begin
    w_entry        = '0;
    w_entry.data   = result_data_i;
    w_entry.hartid = result_hartid_i;
    w_entry.id     = result_id_i;
    w_entry.rd     = result_rd_i;
    w_entry.we     = result_we_i && (result_rd_i != 5'd0);
  end

  // The result clears its bit first, so a same-cycle issue of the same id leaves it set.
  always_comb begin
    w_sb_nxt = r_sb;
    if (w_push) begin
      w_sb_nxt[result_id_i] = 1'b0;
    end
    if (issue_valid_i) begin
      w_sb_nxt[issue_id_i] = 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_count    <= '0;
      r_sb       <= '0;
      r_spurious <= 1'b0;
      r_dup      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= w_wptr_nxt;
      end
      if (w_pop) begin
        r_rptr <= w_rptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_sb       <= w_sb_nxt;
      r_spurious <= w_accept && !w_hit;
      r_dup      <= issue_valid_i && r_sb[issue_id_i];
    end
  end

  assign w_head      = w_empty ? '0 : r_mem[r_rptr];
  assign wb_valid_o  = !w_empty;
  assign wb_data_o   = w_head.data;
  assign wb_hartid_o = w_head.hartid;
  assign wb_id_o     = w_head.id;
  assign wb_rd_o     = w_head.rd;
  assign wb_we_o     = w_head.we;

  assign spurious_o  = r_spurious;
  assign dup_issue_o = r_dup;
  assign busy_o      = (|r_sb) || !w_empty;

endmodule

// File: tb/tb_cvxif_result_collector.sv
// Self-checking bench for cvxif_result_collector: directed vector table, hand sequences
// for backpressure and mid-operation reset, then randomized traffic against a queue model.
module tb_cvxif_result_collector;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic [3:0]  issue_id_i;
  logic        result_valid_i;
  logic        result_ready_o;
  logic [63:0] result_data_i;
  logic [0:0]  result_hartid_i;
  logic [3:0]  result_id_i;
  logic [4:0]  result_rd_i;
  logic        result_we_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [63:0] wb_data_o;
  logic [0:0]  wb_hartid_o;
  logic [3:0]  wb_id_o;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o;
  logic        spurious_o;
  logic        dup_issue_o;
  logic        busy_o;

  int n_cmp  = 0;
  int n_fail = 0;

  cvxif_result_collector dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .issue_valid_i   (issue_valid_i),
    .issue_id_i      (issue_id_i),
    .result_valid_i  (result_valid_i),
    .result_ready_o  (result_ready_o),
    .result_data_i   (result_data_i),
    .result_hartid_i (result_hartid_i),
    .result_id_i     (result_id_i),
    .result_rd_i     (result_rd_i),
    .result_we_i     (result_we_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_data_o       (wb_data_o),
    .wb_hartid_o     (wb_hartid_o),
    .wb_id_o         (wb_id_o),
    .wb_rd_o         (wb_rd_o),
    .wb_we_o         (wb_we_o),
    .spurious_o      (spurious_o),
    .dup_issue_o     (dup_issue_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv;
    logic [3:0]  iid;
    logic        rv;
    logic [3:0]  rid;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] data;
    logic        wbr;
    logic        e_wbv;
    logic [4:0]  e_rd;
    logic        e_we;
    logic [63:0] e_data;
    logic        e_spur;
    logic        e_dup;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [0:0]  hart;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  vec_t vt [15];
  ent_t q [$];
  bit   sb [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid_i   = 1'b0;
    issue_id_i      = '0;
    result_valid_i  = 1'b0;
    result_data_i   = '0;
    result_hartid_i = '0;
    result_id_i     = '0;
    result_rd_i     = '0;
    result_we_i     = 1'b0;
    wb_ready_i      = 1'b0;
  endtask

  task automatic send_result(input logic [3:0] id, input logic [4:0] rd, input logic [63:0] data);
    result_valid_i = 1'b1;
    result_id_i    = id;
    result_rd_i    = rd;
    result_data_i  = data;
    result_we_i    = 1'b1;
  endtask

  initial begin
    //               iv iid rv rid rd we data     wbr  wbv erd ewe edata    sp dup busy
    vt[0]  = '{1, 3, 0, 0, 0, 0, 64'h0,    0,   0, 0, 0, 64'h0,    0, 0, 1};
    vt[1]  = '{0, 0, 1, 3, 5, 1, 64'h1234, 0,   1, 5, 1, 64'h1234, 0, 0, 1};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 64'h0,    1,   0, 0, 0, 64'h0,    0, 0, 0};
    vt[3]  = '{1, 1, 0, 0, 0, 0, 64'h0,    0,   0, 0, 0, 64'h0,    0, 0, 1};
    vt[4]  = '{0, 0, 1, 1, 0, 1, 64'hAA,   0,   1, 0, 0, 64'hAA,   0, 0, 1};
    vt[5]  = '{0, 0, 0, 0, 0, 0, 64'h0,    1,   0, 0, 0, 64'h0,    0, 0, 0};
    vt[6]  = '{0, 0, 1, 7, 6, 1, 64'h77,   0,   0, 0, 0, 64'h0,    1, 0, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 0, 64'h0,    0,   0, 0, 0, 64'h0,    0, 0, 0};
    vt[8]  = '{1, 2, 0, 0, 0, 0, 64'h0,    0,   0, 0, 0, 64'h0,    0, 0, 1};
    vt[9]  = '{1, 2, 0, 0, 0, 0, 64'h0,    0,   0, 0, 0, 64'h0,    0, 1, 1};
    vt[10] = '{0, 0, 0, 0, 0, 0, 64'h0,    0,   0, 0, 0, 64'h0,    0, 0, 1};
    vt[11] = '{1, 2, 1, 2, 9, 1, 64'h22,   0,   1, 9, 1, 64'h22,   0, 1, 1};
    vt[12] = '{0, 0, 0, 0, 0, 0, 64'h0,    1,   0, 0, 0, 64'h0,    0, 0, 1};
    vt[13] = '{0, 0, 1, 2, 4, 0, 64'h33,   0,   1, 4, 0, 64'h33,   0, 0, 1};
    vt[14] = '{0, 0, 0, 0, 0, 0, 64'h0,    1,   0, 0, 0, 64'h0,    0, 0, 0};

    // ---------------- reset values ----------------
    idle_inputs();
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    #2;
    chk("rst_ready", result_ready_o, 0);
    chk("rst_wbv", wb_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_spur", spurious_o, 0);
    chk("rst_dup", dup_issue_o, 0);
    chk("rst_wbdata", wb_data_o, 0);
    step();
    step();
    rst_i = 1'b0;
    #1;
    chk("rel_ready", result_ready_o, 1);

    // ---------------- vector table ----------------
    for (int i = 0; i < 15; i++) begin
      issue_valid_i  = vt[i].iv;
      issue_id_i     = vt[i].iid;
      result_valid_i = vt[i].rv;
      result_id_i    = vt[i].rid;
      result_rd_i    = vt[i].rd;
      result_we_i    = vt[i].we;
      result_data_i  = vt[i].data;
      wb_ready_i     = vt[i].wbr;
      step();
      idle_inputs();
      chk($sformatf("v%0d_wbv", i), wb_valid_o, vt[i].e_wbv);
      chk($sformatf("v%0d_rd", i), wb_rd_o, vt[i].e_rd);
      chk($sformatf("v%0d_we", i), wb_we_o, vt[i].e_we);
      chk($sformatf("v%0d_data", i), wb_data_o, vt[i].e_data);
      chk($sformatf("v%0d_spur", i), spurious_o, vt[i].e_spur);
      chk($sformatf("v%0d_dup", i), dup_issue_o, vt[i].e_dup);
      chk($sformatf("v%0d_busy", i), busy_o, vt[i].e_busy);
      chk($sformatf("v%0d_ready", i), result_ready_o, 1);
    end

    // ---------------- backpressure ----------------
    for (int i = 0; i < 5; i++) begin
      issue_valid_i = 1'b1;
      issue_id_i    = 4'(i);
      step();
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      send_result(4'(k), 5'(k + 1), 64'h100 + 64'(k));
      step();
      chk($sformatf("bp_ready_%0d", k), result_ready_o, (k < 3) ? 1 : 0);
    end
    send_result(4'd4, 5'd5, 64'h104);
    wb_ready_i = 1'b1;
    chk("bp_head0", wb_data_o, 64'h100);
    step();
    chk("bp_ready_after_pop", result_ready_o, 1);
    chk("bp_head1", wb_data_o, 64'h101);
    wb_ready_i = 1'b0;
    step();
    chk("bp_ready_refull", result_ready_o, 0);
    idle_inputs();
    wb_ready_i = 1'b1;
    for (int j = 1; j < 5; j++) begin
      chk($sformatf("bp_drain_v%0d", j), wb_valid_o, 1);
      chk($sformatf("bp_drain_d%0d", j), wb_data_o, 64'h100 + 64'(j));
      chk($sformatf("bp_drain_id%0d", j), wb_id_o, 64'(j));
      step();
    end
    wb_ready_i = 1'b0;
    chk("bp_empty", wb_valid_o, 0);
    chk("bp_busy", busy_o, 0);

    // ---------------- reset mid-operation ----------------
    begin
      logic [3:0] ids [5];
      ids = '{4'd5, 4'd6, 4'd8, 4'd9, 4'd10};
      for (int i = 0; i < 5; i++) begin
        issue_valid_i = 1'b1;
        issue_id_i    = ids[i];
        step();
      end
      issue_valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
        send_result(ids[i], 5'd3, 64'(i));
        step();
      end
      send_result(4'd12, 5'd3, 64'hDEAD);
      step();
      idle_inputs();
      chk("mr_pre_spur", spurious_o, 1);
      chk("mr_pre_wbv", wb_valid_o, 1);
      #2 rst_i = 1'b1;
      #1;
      chk("mr_wbv", wb_valid_o, 0);
      chk("mr_busy", busy_o, 0);
      chk("mr_ready", result_ready_o, 0);
      chk("mr_spur", spurious_o, 0);
      step();
      rst_i = 1'b0;
      #1;
      chk("mr_rel_ready", result_ready_o, 1);
      chk("mr_rel_busy", busy_o, 0);
      chk("mr_rel_wbv", wb_valid_o, 0);
    end

    // ---------------- randomized against queue model ----------------
    q.delete();
    for (int i = 0; i < 16; i++) sb[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit   m_ready, acc, hit, e_sp, e_dup, any;
      ent_t e;
      issue_valid_i   = ($urandom_range(0, 2) == 0);
      issue_id_i      = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      result_valid_i  = ($urandom_range(0, 1) == 1);
      result_id_i     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      result_rd_i     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      result_we_i     = 1'($urandom_range(0, 1));
      result_hartid_i = 1'($urandom_range(0, 1));
      result_data_i   = {32'($urandom), 32'($urandom)};
      wb_ready_i      = ($urandom_range(0, 9) < 3);

      m_ready = (q.size() < 4);
      acc     = result_valid_i && m_ready;
      hit     = sb[result_id_i];
      e_sp    = acc && !hit;
      e_dup   = issue_valid_i && sb[issue_id_i];
      if (q.size() > 0 && wb_ready_i) void'(q.pop_front());
      if (acc && hit) begin
        e.data = result_data_i;
        e.hart = result_hartid_i;
        e.id   = result_id_i;
        e.rd   = result_rd_i;
        e.we   = result_we_i && (result_rd_i != 0);
        q.push_back(e);
        sb[result_id_i] = 1'b0;
      end
      if (issue_valid_i) sb[issue_id_i] = 1'b1;

      step();

      any = 1'b0;
      for (int i = 0; i < 16; i++) any |= sb[i];
      chk("rnd_wbv", wb_valid_o, (q.size() > 0) ? 1 : 0);
      chk("rnd_ready", result_ready_o, (q.size() < 4) ? 1 : 0);
      chk("rnd_spur", spurious_o, e_sp);
      chk("rnd_dup", dup_issue_o, e_dup);
      chk("rnd_busy", busy_o, (any || q.size() > 0) ? 1 : 0);
      if (q.size() > 0) begin
        chk("rnd_data", wb_data_o, q[0].data);
        chk("rnd_hart", wb_hartid_o, q[0].hart);
        chk("rnd_id", wb_id_o, q[0].id);
        chk("rnd_rd", wb_rd_o, q[0].rd);
        chk("rnd_we", wb_we_o, q[0].we);
      end else begin
        chk("rnd_empty_data", wb_data_o, 0);
      end
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cvxif_result_collector.md
# cvxif_result_collector

Core-side receiver for coprocessor result transactions on the CV-X-IF result channel. It accepts results (data, hartid, id, rd, we) with a valid/ready handshake and buffers them in a small FIFO. It presents them to the register-file writeback arbiter through a second valid/ready handshake. A per-id scoreboard of issued-but-unanswered instructions flags results that match no outstanding instruction, and issues that reuse a busy id.

## Interface
- Depth, 4: FIFO entries; power of two, at least 2.
- IdWidth, 4: instruction id width; the scoreboard holds 2**IdWidth bits.
- HartIdWidth, 1: hart id width.
- XLEN, 64: result data width.

- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- issue_valid_i  in  1  an instruction with issue_id_i was offloaded this cycle.
- issue_id_i  in  IdWidth  id of the offloaded instruction.
- result_valid_i  in  1  coprocessor result present.
- result_ready_o  out  1  collector can accept a result.
- result_data_i  in  XLEN  result value.
- result_hartid_i  in  HartIdWidth  hart id.
- result_id_i  in  IdWidth  instruction id.
- result_rd_i  in  5  destination register.
- result_we_i  in  1  register write requested.
- wb_valid_o  out  1  FIFO head valid.
- wb_ready_i  in  1  writeback arbiter takes the head.
- wb_data_o  out  XLEN  head data.
- wb_hartid_o  out  HartIdWidth  head hart id.
- wb_id_o  out  IdWidth  head id.
- wb_rd_o  out  5  head rd.
- wb_we_o  out  1  head write enable.
- spurious_o  out  1  one-cycle pulse: an accepted result's id was not outstanding.
- dup_issue_o  out  1  one-cycle pulse: an issue named an id that was already outstanding.
- busy_o  out  1  any scoreboard bit set, or FIFO not empty.

## Operation
- **Accept:** a result is accepted when result_valid_i and result_ready_o are both high. result_ready_o = !full && !rst_i. There is no bypass: a full FIFO refuses the result even if it pops in the same cycle.
- **Spurious result** (scoreboard bit for result_id_i clear before the edge): the result is accepted but not pushed. spurious_o pulses high in the next cycle.
- **Valid result:** pushed into the FIFO, and the scoreboard bit is cleared.
- **rd = 0:** stored with we forced to 0.
- **we = 0:** the entry is still stored and delivered, to signal completion.
- **Pop:** happens when wb_valid_o and wb_ready_i are both high. wb_valid_o = !empty. The wb_* outputs show the head entry combinationally from storage; they are 0 when the FIFO is empty.
- **FIFO state:** read pointer, write pointer and a count register of width clog2(Depth)+1. Pointers wrap from Depth-1 to 0. Push and pop in the same cycle (not full, not empty) leave the count unchanged.
- **Scoreboard:**
  - An issue sets bit issue_id_i.
  - An issue whose bit is already set keeps it set, and dup_issue_o pulses in the next cycle.
  - An issue and an accepted result with the same id in one cycle: the result is checked against the pre-edge bit, then the set wins, so the bit ends at 1.
  - An issue and a result with different ids in one cycle are independent.
- **busy_o** is combinational from the registered state.
- **Reset mid-operation:** FIFO contents are discarded, pointers, count and scoreboard clear, and pending pulses are dropped. Results in flight are lost by design; the core flushes around reset.

## Timing
- **Reset values:** result_ready_o 0 while rst_i is high, and 1 from the first cycle after release. All other outputs are 0.
- **Latency:**
  - A result accepted at edge N appears on wb_* in the cycle after edge N (one cycle).
  - A pop at edge M exposes the next entry immediately after edge M.
- **Error pulses:** spurious_o and dup_issue_o are registered, high for exactly the one cycle after the offending edge.
- **Throughput:** one result and one writeback per cycle in steady state.
- **Full cycle:** result_ready_o is low during a cycle in which the FIFO is full, and rises in the cycle after a pop.

## Test plan
- **Basic path:** reset, issue id 3, then result id 3, rd 5, data 0x1234, we 1. Expect wb_valid_o one cycle later with rd 5, data 0x1234, we 1. After wb_ready_i, busy_o falls to 0.
- **rd = 0:** issue id 1, then result id 1, rd 0, we 1. Expect a wb entry with we 0; spurious_o stays 0.
- **Spurious result:** result id 7 with no issue. Expect it accepted, no wb_valid_o, and spurious_o high for exactly one cycle.
- **Backpressure:** issue ids 0..4 with wb_ready_i held 0, then send 5 results.
  - result_ready_o drops after 4 are accepted.
  - With one pop, result_ready_o rises the next cycle and result 5 is accepted.
  - Entries drain in order 0..4.
- **Same-id collision:** issue id 2 twice. Expect dup_issue_o. Then, in one cycle, a result for id 2 plus a new issue of id 2: the result is not spurious and the bit remains set.
- **Reset mid-operation:** 3 entries queued and 2 ids outstanding. Assert rst_i asynchronously between edges. Expect wb_valid_o 0, busy_o 0 and result_ready_o 0 immediately, and result_ready_o 1 after release.
